// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer with configurable width and shift
// direction, a bit-qualify input, a word-boundary counter, a valid/ready output
// holding register and sticky overrun detection. All state updates on the
// falling edge of clk.
// Optional even-parity frame bit: define SIPO_DESER_PARITY_EN.
module sipo_deserializer #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned SHIFT_LEFT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             serial_data_in,
  input  logic             serial_valid,
  output logic [WIDTH-1:0] shift_data_out,
  output logic [WIDTH-1:0] parallel_data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             parity_err
);

`ifdef SIPO_DESER_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam int unsigned CNT_W = $clog2(FRAME + 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pdata_q, pdata_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             perr_q, perr_d;
  logic             last_bit_c;
  logic             data_bit_c;
  logic [WIDTH-1:0] sr_shift_c;

  // Frame position decode: which accepted bit closes the frame, which feed sr
  always_comb begin
    last_bit_c = serial_valid && (cnt_q == CNT_W'(FRAME - 1));
`ifdef SIPO_DESER_PARITY_EN
    data_bit_c = serial_valid && (cnt_q != CNT_W'(WIDTH));
`else
    data_bit_c = serial_valid;
`endif
  end

  // Shift-register next value for the configured direction
  always_comb begin
    if (SHIFT_LEFT != 0) begin
      sr_shift_c = {sr_q[WIDTH-2:0], serial_data_in};
    end else begin
      sr_shift_c = {serial_data_in, sr_q[WIDTH-1:1]};
    end
  end

  // Next-state: shifting, counting, word completion, handshake and overrun
  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    pdata_d = pdata_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    perr_d  = perr_q;

    if (data_bit_c) begin
      sr_d = sr_shift_c;
    end
    if (serial_valid) begin
      cnt_d = last_bit_c ? '0 : cnt_q + CNT_W'(1);
    end

    if (last_bit_c) begin
      // The parity bit never enters sr, so sr_d is the data word either way
      pdata_d = sr_d;
      valid_d = 1'b1;
      if (valid_q && !out_ready) begin
        ovr_d = 1'b1;
      end
`ifdef SIPO_DESER_PARITY_EN
      perr_d = (^sr_d) ^ serial_data_in;
`else
      perr_d = 1'b0;
`endif
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers; clear has priority over every other update
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      pdata_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else if (clear) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      pdata_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      pdata_q <= pdata_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
    end
  end

  assign shift_data_out    = sr_q;
  assign parallel_data_out = pdata_q;
  assign out_valid         = valid_q;
  assign overrun           = ovr_q;
  assign parity_err        = perr_q;

endmodule
